// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-side load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int         TMO_W   = 8;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Illegal size or an address not naturally aligned to the access size.
  function automatic logic access_bad(input logic [3:0] be, input logic [1:0] ofs);
    case (be)
      BE_BYTE: return 1'b0;
      BE_HALF: return ofs[0];
      BE_WORD: return ofs != 2'b00;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the addressed lanes down and sign/zero-extend.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [3:0]  byte_en_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (byte_en_i)
      BE_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      BE_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end
endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: drives a word-addressed req/gnt/rvalid bus, stalls the
// pipeline while an access is in flight, and flags misaligned/timed-out accesses.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  // Last counter value before the limit: a stalled cycle here is the final one allowed.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  lsu_req_t         req_q, req_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      ld_data;
  logic [31:0]      st_data;
  logic             tmo_hit;

  lsu_load_align u_align (
    .rdata_i   (bus_rdata_i),
    .offset_i  (req_q.addr[1:0]),
    .byte_en_i (req_q.be),
    .unsigned_i(req_q.uns),
    .data_o    (ld_data)
  );

  assign tmo_hit = (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Progress (gnt/rvalid) is checked before the limit so a late response still wins.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (req_valid_i) begin
          req_d = '{we: req_we_i, be: req_byte_en_i, uns: req_unsigned_i,
                    addr: req_addr_i, wdata: req_wdata_i};
          cnt_d = '0;
          if (access_bad(req_byte_en_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_d = req_q.we ? RESP : WAIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (req_q.be)
      BE_BYTE: st_data = {4{req_q.wdata[7:0]}};
      BE_HALF: st_data = {2{req_q.wdata[15:0]}};
      default: st_data = req_q.wdata;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    stall_o     = ((state_q == IDLE) && req_valid_i) || (state_q == REQ) || (state_q == WAIT);
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    case (state_q)
      REQ: begin
        bus_req_o   = 1'b1;
        bus_we_o    = req_q.we;
        bus_addr_o  = {req_q.addr[31:2], 2'b00};
        bus_be_o    = req_q.be << req_q.addr[1:0];
        // write data lanes only carry meaning for stores
        bus_wdata_o = req_q.we ? st_data : '0;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = rdata_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: transaction-level model checked every cycle,
// plus hand-computed expectations for each directed access.
module tb_lsu_mem_if;
  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [3:0]  req_byte_en_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, stall_o;
  logic [31:0] rsp_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  lsu_mem_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_byte_en_i(req_byte_en_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit illegal(input logic [3:0] be, input logic [1:0] a);
    if (be == 4'd1) return 1'b0;
    if (be == 4'd3) return (a % 2) == 1;
    if (be == 4'd15) return a != 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [3:0] be,
                                          input logic [1:0] a, input bit uns);
    logic [31:0] v;
    v = rd >> (8 * a);
    if (be == 4'd1) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (be == 4'd3) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  bit          m_busy, m_gnt, m_resp, m_err, m_we, m_uns;
  int          m_cyc;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd, m_data;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 0; m_gnt = 0; m_resp = 0; m_err = 0; m_cyc = 0;
      m_we = 0; m_uns = 0; m_be = '0; m_addr = '0; m_wd = '0; m_data = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (!m_gnt && bus_gnt_i) begin
        if (m_we) begin m_busy = 0; m_resp = 1; end
        else m_gnt = 1;
      end else if (m_gnt && bus_rvalid_i) begin
        m_busy = 0; m_resp = 1;
        m_data = extract(bus_rdata_i, m_be, m_addr[1:0], m_uns);
      end else begin
        m_cyc++;
        if (m_cyc >= TMO) begin m_busy = 0; m_resp = 1; m_err = 1; end
      end
    end else if (req_valid_i) begin
      m_we = req_we_i; m_be = req_byte_en_i; m_uns = req_unsigned_i;
      m_addr = req_addr_i; m_wd = req_wdata_i; m_data = '0; m_err = 0;
      m_gnt = 0; m_cyc = 0;
      if (illegal(req_byte_en_i, req_addr_i[1:0])) begin m_err = 1; m_resp = 1; end
      else m_busy = 1;
    end
  end

  always @(negedge clk_i) begin
    bit          e_ready, e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    e_ready = !m_busy && !m_resp;
    e_req   = m_busy && !m_gnt;
    e_be    = m_be << m_addr[1:0];
    if (m_be == 4'd1)      e_wd = (m_wd % 256) * 32'h01010101;
    else if (m_be == 4'd3) e_wd = (m_wd % 65536) * 32'h00010001;
    else                   e_wd = m_wd;
    chk("ready", 32'(req_ready_o), 32'(e_ready));
    chk("stall", 32'(stall_o), 32'((e_ready && req_valid_i) || m_busy));
    chk("bus_req", 32'(bus_req_o), 32'(e_req));
    chk("bus_we", 32'(bus_we_o), 32'(e_req && m_we));
    chk("bus_addr", bus_addr_o, e_req ? (m_addr / 4) * 4 : 32'd0);
    chk("bus_be", 32'(bus_be_o), e_req ? 32'(e_be) : 32'd0);
    chk("bus_wdata", bus_wdata_o, (e_req && m_we) ? e_wd : 32'd0);
    chk("rsp_valid", 32'(rsp_valid_o), 32'(m_resp));
    chk("rsp_err", 32'(rsp_err_o), 32'(m_resp && m_err));
    chk("rsp_rdata", rsp_rdata_o, (m_resp && !m_err) ? m_data : 32'd0);
  end

  // ---------------- bus responder ----------------
  int          g_dly = 0, r_dly = 0;
  bit          stray_rv = 0;
  logic [31:0] rd_cfg = '0;
  int          rq_n = 0, wt_n = 0;
  bit          wt = 0;

  always @(posedge clk_i) begin
    #1;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i = rd_cfg;
    if (!rst_ni || rsp_valid_o) begin rq_n = 0; wt = 0; end
    if (wt) begin
      bus_rvalid_i = (wt_n == r_dly);
      if (bus_rvalid_i) wt = 0;
      wt_n++;
    end else begin
      bus_rvalid_i = stray_rv;
      if (bus_req_o) begin
        if (rq_n == g_dly) begin
          bus_gnt_i = 1'b1; rq_n = 0; wt = !bus_we_o; wt_n = 0;
        end else rq_n++;
      end else rq_n = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  int          r_lat, r_reqn;
  logic [31:0] r_rd, r_addr, r_wd;
  logic [3:0]  r_be;
  bit          r_err;

  // Called at posedge+1 with the DUT idle; acceptance cycle is cycle 0.
  task automatic run_txn(input bit we, input logic [3:0] be, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid_i = 1'b1; req_we_i = we; req_byte_en_i = be;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wd;
    r_lat = 0; r_reqn = 0; r_rd = '0; r_err = 0; r_addr = '0; r_wd = '0; r_be = '0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (bus_req_o) begin
        r_reqn++; r_addr = bus_addr_o; r_be = bus_be_o; r_wd = bus_wdata_o;
      end
      if (rsp_valid_o) begin
        r_lat = k; r_rd = rsp_rdata_o; r_err = rsp_err_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (r_lat == 0) begin
      total++; bad++;
      $display("FAIL rsp_wait act=none exp=rsp_valid within 40 cycles");
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    int n;
    // reset state
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_txn(1, 4'hF, 0, 32'h1000, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 2); chk("sw_addr", r_addr, 32'h1000);
    chk("sw_be", 32'(r_be), 32'hF); chk("sw_wd", r_wd, 32'hDEADBEEF);
    chk("sw_err", 32'(r_err), 0);

    run_txn(1, 4'h1, 0, 32'h2003, 32'h000000A5);
    chk("sb_be", 32'(r_be), 32'h8); chk("sb_wd", r_wd, 32'hA5A5A5A5);
    chk("sb_addr", r_addr, 32'h2000);

    rd_cfg = 32'h00008000;
    run_txn(0, 4'h1, 0, 32'h11, 0);
    chk("lb_lat", r_lat, 3); chk("lb_data", r_rd, 32'hFFFFFF80);
    run_txn(0, 4'h1, 1, 32'h11, 0);
    chk("lbu_data", r_rd, 32'h00000080);

    rd_cfg = 32'h80010000;
    run_txn(0, 4'h3, 0, 32'h2, 0);
    chk("lh_data", r_rd, 32'hFFFF8001);
    run_txn(0, 4'h3, 1, 32'h2, 0);
    chk("lhu_data", r_rd, 32'h00008001);

    run_txn(0, 4'hF, 0, 32'h6, 0);
    chk("lw_mis_lat", r_lat, 1); chk("lw_mis_err", 32'(r_err), 1);
    chk("lw_mis_req", r_reqn, 0); chk("lw_mis_rd", r_rd, 0);
    run_txn(1, 4'h3, 0, 32'h3, 32'h1234);
    chk("sh_mis_err", 32'(r_err), 1); chk("sh_mis_req", r_reqn, 0);
    run_txn(0, 4'h5, 0, 32'h0, 0);
    chk("be5_err", 32'(r_err), 1); chk("be5_lat", r_lat, 1);

    // timeout in REQ, then gnt exactly at the limit
    g_dly = 999;
    run_txn(1, 4'hF, 0, 32'h40, 32'h1);
    chk("tmo_reqn", r_reqn, 4); chk("tmo_err", 32'(r_err), 1); chk("tmo_lat", r_lat, 5);
    g_dly = 3;
    run_txn(1, 4'hF, 0, 32'h44, 32'h2);
    chk("gnt_lim_err", 32'(r_err), 0); chk("gnt_lim_lat", r_lat, 5);

    // timeout while waiting for read data
    g_dly = 1; r_dly = 999;
    run_txn(0, 4'hF, 0, 32'h48, 0);
    chk("tmo_wait_lat", r_lat, 6); chk("tmo_wait_err", 32'(r_err), 1);
    chk("tmo_wait_rd", r_rd, 0);

    // rvalid while still in REQ must be ignored
    r_dly = 0; stray_rv = 1; rd_cfg = 32'h12345678;
    run_txn(0, 4'hF, 0, 32'h8, 0);
    stray_rv = 0;
    chk("stray_lat", r_lat, 4); chk("stray_rd", r_rd, 32'h12345678);

    // request held through RESP is taken one cycle later
    g_dly = 0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_byte_en_i = 4'h1;
    req_addr_i = 32'h3000; req_wdata_i = 32'h11;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); if (rsp_valid_o) n++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); if (rsp_valid_o) n++;
      @(posedge clk_i); #1;
    end
    chk("b2b_rsps", n, 2);

    // async reset in the middle of WAIT
    r_dly = 999;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_byte_en_i = 4'hF; req_addr_i = 32'h20;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_bus_req", 32'(bus_req_o), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1; r_dly = 0; rd_cfg = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    run_txn(0, 4'hF, 0, 32'h24, 0);
    chk("post_rst_lat", r_lat, 3); chk("post_rst_rd", r_rd, 32'hCAFEF00D);
    chk("post_rst_err", 32'(r_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
